bit_index_serializer: RTL

BIT_INDEX_SERIALIZER -- requirements
Module: bit_index_serializer

---
 rtl/aptpu_pkg.sv | 15 +
 rtl/bit_index_serializer_p_encoder.sv | 26 ++
 rtl/bit_index_serializer.sv | 105 ++++++++++
 3 files changed

// File: rtl/aptpu_pkg.sv
// Shared definitions for the bit-index serializer: FSM state encodings and
// the index-width helper used to size index ports.
package aptpu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Width of an index into a BW-bit vector; never narrower than one bit.
  function automatic int idx_width(input int bw);
    return (bw > 1) ? $clog2(bw) : 1;
  endfunction

endpackage

// File: rtl/bit_index_serializer_p_encoder.sv
// Priority encoder returning the index of the lowest set bit of in_vec.
// idx is 0 and found is 0 when in_vec is all-zero.
module P_Encoder
  import aptpu_pkg::*;
#(
  parameter  int BW = 8,
  localparam int IW = idx_width(BW)
) (
  input  logic [BW-1:0] in_vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scanning downward lets the lowest set bit be the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = BW - 1; i >= 0; i--) begin
      if (in_vec[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit_index_serializer.sv
// Serializes a word into one beat per set bit, lowest index first; an
// all-zero word yields a single beat flagged out_zero.
module bit_index_serializer
  import aptpu_pkg::*;
#(
  parameter  int BW = 8,
  parameter  int TW = 4,
  localparam int IW = idx_width(BW),
  localparam int SW = IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_word,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [TW-1:0] out_tag,
  output logic          out_last,
  output logic          out_zero,
  output logic [SW-1:0] out_seq,
  output state_e        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready/out_valid decode the registered state only, so neither depends
  // combinationally on the opposite side; beats hold steady while stalled.

  localparam logic [BW-1:0] RES_ONE = BW'(1);
  localparam logic [SW-1:0] SEQ_ONE = SW'(1);

  state_e        state_q, state_d;
  logic [BW-1:0] res_q, res_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [SW-1:0] seq_q, seq_d;

  logic [IW-1:0] low_idx;
  logic          any_set;
  logic [BW-1:0] res_clr;

  P_Encoder #(
    .BW(BW)
  ) u_p_encoder (
    .in_vec(res_q),
    .idx   (low_idx),
    .found (any_set)
  );

  // Clearing the lowest set bit; zero afterwards means this is the last beat.
  assign res_clr   = res_q & (res_q - RES_ONE);

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_EMIT);
  assign out_idx   = low_idx;
  assign out_tag   = tag_q;
  assign out_last  = (res_clr == '0);
  assign out_zero  = ~any_set;
  assign out_seq   = seq_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    tag_d   = tag_q;
    seq_d   = seq_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_EMIT;
          res_d   = in_word;
          tag_d   = in_tag;
          seq_d   = '0;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            state_d = ST_IDLE;
          end else begin
            res_d = res_clr;
            seq_d = seq_q + SEQ_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      tag_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      seq_q   <= seq_d;
    end
  end

endmodule
